rain_frame_sequencer: RTL and testbench

Synchronous frame/animation controller for the VGA glyph-rain display. It replaces the vsync-clocked frame counter with a `clk`-domain sequencer that counts frames, runs the intro drop phase, and handles speed, pause and single-step. It also commits palette and video-mode selections only at frame boundaries. Its outputs feed the glyph/palette datapath and the `hvsync_generator` mode input.

---
 rtl/glyph_mode_pkg.sv | 28 ++
 rtl/sync_rise_detect.sv | 46 ++++
 rtl/rain_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_rain_frame_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/glyph_mode_pkg.sv
// glyph_mode_pkg: shared types and encodings for the glyph-rain frame sequencer.
// Revision 1.0
`default_nettype none

package glyph_mode_pkg;

  localparam int FRAME_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_INTRO = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_t;

  localparam logic [1:0] c_SPEED_DIV1 = 2'd0;
  localparam logic [1:0] c_SPEED_DIV2 = 2'd1;
  localparam logic [1:0] c_SPEED_DIV4 = 2'd2;
  localparam logic [1:0] c_SPEED_DIV8 = 2'd3;

  // Mode codes understood by hvsync_generator.
  localparam logic [1:0] c_MODE_640X480 = 2'd0;
  localparam logic [1:0] c_MODE_800X600 = 2'd1;
  localparam logic [1:0] c_MODE_1024X768 = 2'd2;
  localparam logic [1:0] c_MODE_1280X720 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: optional N-flop synchronizer followed by a rising-edge detector.
// Revision 1.0
`default_nettype none

module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic w_d;
  logic r_q;
  logic r_arm;

  generate
    if (STAGES == 0) begin : g_nosync
      assign w_d = i_d;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= (r_sync << 1) | STAGES'(i_d);
      end
      assign w_d = r_sync[STAGES-1];
    end
  endgenerate

  // r_arm masks the first cycle after reset so a level already high is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= 1'b0;
      r_arm <= 1'b0;
    end else begin
      r_q   <= w_d;
      r_arm <= 1'b1;
    end
  end

  assign o_rise = w_d & ~r_q & r_arm;

endmodule

`default_nettype wire

// File: rtl/rain_frame_sequencer.sv
// rain_frame_sequencer: frame counter, intro phase, speed/pause/step control and
// frame-boundary commit of palette and video mode. Revision 1.0
`default_nettype none

module rain_frame_sequencer
  import glyph_mode_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DIV_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_vsync,
  input  logic               i_pause_req,
  input  logic               i_step,
  input  logic [1:0]         i_speed,
  input  logic [1:0]         i_pid_req,
  input  logic [1:0]         i_mode_req,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_intro_done,
  output logic               o_frame_tick,
  output logic [1:0]         o_pid,
  output logic [1:0]         o_mode,
  output logic               o_paused
);

  logic               w_vs_rise;
  logic               w_step_rise;
  logic [DIV_W-1:0]   w_div_max;
  logic [FRAME_W-1:0] w_frame_inc;
  logic               w_frame_last;

  seq_state_t         r_state;
  logic               r_was_intro;
  logic [DIV_W-1:0]   r_div;
  logic               r_step_pend;
  logic               r_bnd;
  logic [FRAME_W-1:0] r_frame;
  logic               r_intro_done;
  logic               r_tick;
  logic [1:0]         r_pid;
  logic [1:0]         r_mode;
  logic               r_paused;

  sync_rise_detect #(.STAGES(0)) u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (i_vsync),
    .o_rise (w_vs_rise)
  );

  sync_rise_detect #(.STAGES(2)) u_step_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (i_step),
    .o_rise (w_step_rise)
  );

  assign w_div_max    = DIV_W'((32'd1 << i_speed) - 32'd1);
  assign w_frame_inc  = r_frame + FRAME_W'(1);
  assign w_frame_last = (r_frame == {FRAME_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_INTRO;
      r_was_intro  <= 1'b0;
      r_div        <= '0;
      r_step_pend  <= 1'b0;
      r_bnd        <= 1'b0;
      r_frame      <= '0;
      r_intro_done <= 1'b0;
      r_tick       <= 1'b0;
      r_pid        <= 2'd0;
      r_mode       <= c_MODE_640X480;
      r_paused     <= 1'b0;
    end else begin
      r_bnd  <= w_vs_rise;
      r_tick <= 1'b0;

      if (r_bnd) begin
        r_pid       <= i_pid_req;
        // A pending step is either consumed here or stale; it never survives a boundary.
        r_step_pend <= 1'b0;

        if (i_mode_req != r_mode) begin
          r_mode       <= i_mode_req;
          r_frame      <= '0;
          r_div        <= '0;
          r_intro_done <= 1'b0;
          r_state      <= ST_INTRO;
          r_was_intro  <= 1'b0;
          r_paused     <= 1'b0;
          r_tick       <= 1'b1;
        end else begin
          case (r_state)
            ST_INTRO, ST_RUN: begin
              if (i_pause_req) begin
                r_state     <= ST_PAUSE;
                r_was_intro <= (r_state == ST_INTRO);
                r_div       <= '0;
                r_paused    <= 1'b1;
              end else if (r_div == w_div_max) begin
                r_div   <= '0;
                r_frame <= w_frame_inc;
                r_tick  <= 1'b1;
                if (r_state == ST_INTRO && w_frame_last) begin
                  r_state      <= ST_RUN;
                  r_intro_done <= 1'b1;
                end
              end else begin
                r_div <= r_div + DIV_W'(1);
              end
            end
            ST_PAUSE: begin
              if (!i_pause_req) begin
                r_state  <= r_was_intro ? ST_INTRO : ST_RUN;
                r_paused <= 1'b0;
              end else if (r_step_pend) begin
                r_frame <= w_frame_inc;
                r_tick  <= 1'b1;
                // Stepping across the intro wrap ends the intro phase as well.
                if (r_was_intro && w_frame_last) begin
                  r_was_intro  <= 1'b0;
                  r_intro_done <= 1'b1;
                end
              end
            end
            default: r_state <= ST_INTRO;
          endcase
        end
      end

      if (w_step_rise) r_step_pend <= 1'b1;
    end
  end

  assign o_frame      = r_frame;
  assign o_intro_done = r_intro_done;
  assign o_frame_tick = r_tick;
  assign o_pid        = r_pid;
  assign o_mode       = r_mode;
  assign o_paused     = r_paused;

endmodule

`default_nettype wire

// File: tb/tb_rain_frame_sequencer.sv
// tb_rain_frame_sequencer: directed self-checking bench for rain_frame_sequencer.
// Revision 1.0
`default_nettype none

module tb_rain_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_pause_req = 1'b0;
  logic       i_step = 1'b0;
  logic [1:0] i_speed = 2'd0;
  logic [1:0] i_pid_req = 2'd0;
  logic [1:0] i_mode_req = 2'd0;
  logic [9:0] o_frame;
  logic       o_intro_done;
  logic       o_frame_tick;
  logic [1:0] o_pid;
  logic [1:0] o_mode;
  logic       o_paused;

  int total = 0;
  int bad = 0;
  int ticks = 0;

  rain_frame_sequencer #(.FRAME_W(10), .DIV_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vsync      (i_vsync),
    .i_pause_req  (i_pause_req),
    .i_step       (i_step),
    .i_speed      (i_speed),
    .i_pid_req    (i_pid_req),
    .i_mode_req   (i_mode_req),
    .o_frame      (o_frame),
    .o_intro_done (o_intro_done),
    .o_frame_tick (o_frame_tick),
    .o_pid        (o_pid),
    .o_mode       (o_mode),
    .o_paused     (o_paused)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_frame_tick) ticks = ticks + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic boundary();
    i_vsync = 1'b1;
    cyc(2);
    i_vsync = 1'b0;
    cyc(2);
  endtask

  task automatic step_edge();
    i_step = 1'b1;
    cyc(4);
    i_step = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    total++; if (o_frame !== 10'd0) begin bad++; $display("FAIL reset_frame: got %0d want 0", o_frame); end
    total++; if (o_intro_done !== 1'b0) begin bad++; $display("FAIL reset_intro_done: got %b want 0", o_intro_done); end
    total++; if (o_frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", o_frame_tick); end
    total++; if (o_pid !== 2'd0) begin bad++; $display("FAIL reset_pid: got %0d want 0", o_pid); end
    total++; if (o_mode !== 2'd0) begin bad++; $display("FAIL reset_mode: got %0d want 0", o_mode); end
    total++; if (o_paused !== 1'b0) begin bad++; $display("FAIL reset_paused: got %b want 0", o_paused); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_intro_wrap();
    int t0;
    t0 = ticks;
    // First boundary: exact latency of frame update and tick.
    i_vsync = 1'b1;
    cyc(1);
    total++; if (o_frame !== 10'd0 || o_frame_tick !== 1'b0) begin bad++; $display("FAIL latency_early: frame=%0d tick=%b want 0/0", o_frame, o_frame_tick); end
    cyc(1);
    i_vsync = 1'b0;
    total++; if (o_frame !== 10'd1 || o_frame_tick !== 1'b1) begin bad++; $display("FAIL latency_update: frame=%0d tick=%b want 1/1", o_frame, o_frame_tick); end
    cyc(1);
    total++; if (o_frame_tick !== 1'b0) begin bad++; $display("FAIL latency_tick_width: tick=%b want 0", o_frame_tick); end
    cyc(1);
    for (int k = 2; k <= 1023; k++) begin
      boundary();
      total++; if (o_frame !== 10'(k) || o_intro_done !== 1'b0) begin bad++; $display("FAIL intro_count: frame=%0d done=%b want %0d/0", o_frame, o_intro_done, k); end
    end
    boundary();
    total++; if (o_frame !== 10'd0) begin bad++; $display("FAIL intro_wrap_frame: got %0d want 0", o_frame); end
    total++; if (o_intro_done !== 1'b1) begin bad++; $display("FAIL intro_wrap_done: got %b want 1", o_intro_done); end
    total++; if (ticks - t0 !== 1024) begin bad++; $display("FAIL intro_tick_count: got %0d want 1024", ticks - t0); end
  endtask

  task automatic test_speed();
    int exp_spd [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    i_speed = 2'd2;
    for (int k = 0; k < 12; k++) begin
      boundary();
      total++; if (o_frame !== 10'(exp_spd[k])) begin bad++; $display("FAIL speed4_b%0d: frame=%0d want %0d", k + 1, o_frame, exp_spd[k]); end
    end
    i_speed = 2'd0;
    total++; if (o_intro_done !== 1'b1) begin bad++; $display("FAIL speed_intro_done: got %b want 1", o_intro_done); end
  endtask

  task automatic test_pause_step();
    repeat (34) boundary();
    total++; if (o_frame !== 10'd37) begin bad++; $display("FAIL pause_pre_frame: got %0d want 37", o_frame); end
    i_pause_req = 1'b1;
    boundary();
    total++; if (o_paused !== 1'b1 || o_frame !== 10'd37) begin bad++; $display("FAIL pause_enter: paused=%b frame=%0d want 1/37", o_paused, o_frame); end
    for (int k = 0; k < 10; k++) begin
      boundary();
      total++; if (o_frame !== 10'd37 || o_paused !== 1'b1) begin bad++; $display("FAIL pause_hold: frame=%0d paused=%b want 37/1", o_frame, o_paused); end
    end
    step_edge();
    boundary();
    total++; if (o_frame !== 10'd38) begin bad++; $display("FAIL step1: frame=%0d want 38", o_frame); end
    step_edge();
    boundary();
    total++; if (o_frame !== 10'd39 || o_paused !== 1'b1) begin bad++; $display("FAIL step2: frame=%0d paused=%b want 39/1", o_frame, o_paused); end
    i_pause_req = 1'b0;
    boundary();
    total++; if (o_paused !== 1'b0 || o_frame !== 10'd39) begin bad++; $display("FAIL resume: paused=%b frame=%0d want 0/39", o_paused, o_frame); end
    boundary();
    total++; if (o_frame !== 10'd40 || o_intro_done !== 1'b1) begin bad++; $display("FAIL resume_count: frame=%0d done=%b want 40/1", o_frame, o_intro_done); end
  endtask

  task automatic test_mode_restart();
    repeat (460) boundary();
    total++; if (o_frame !== 10'd500) begin bad++; $display("FAIL mode_pre_frame: got %0d want 500", o_frame); end
    cyc(1);
    i_pid_req  = 2'd3;
    i_mode_req = 2'd2;
    cyc(3);
    total++; if (o_pid !== 2'd0 || o_mode !== 2'd0) begin bad++; $display("FAIL mode_midframe: pid=%0d mode=%0d want 0/0", o_pid, o_mode); end
    i_vsync = 1'b1;
    cyc(1);
    total++; if (o_pid !== 2'd0 || o_mode !== 2'd0 || o_frame !== 10'd500) begin bad++; $display("FAIL mode_early: pid=%0d mode=%0d frame=%0d want 0/0/500", o_pid, o_mode, o_frame); end
    cyc(1);
    i_vsync = 1'b0;
    total++; if (o_mode !== 2'd2 || o_pid !== 2'd3) begin bad++; $display("FAIL mode_commit: mode=%0d pid=%0d want 2/3", o_mode, o_pid); end
    total++; if (o_frame !== 10'd0 || o_intro_done !== 1'b0 || o_frame_tick !== 1'b1) begin bad++; $display("FAIL mode_restart: frame=%0d done=%b tick=%b want 0/0/1", o_frame, o_intro_done, o_frame_tick); end
    cyc(2);
    boundary();
    total++; if (o_frame !== 10'd1 || o_intro_done !== 1'b0) begin bad++; $display("FAIL mode_intro: frame=%0d done=%b want 1/0", o_frame, o_intro_done); end
  endtask

  task automatic test_priority();
    i_pause_req = 1'b1;
    step_edge();
    i_mode_req = 2'd1;
    boundary();
    total++; if (o_mode !== 2'd1 || o_paused !== 1'b0 || o_frame !== 10'd0) begin bad++; $display("FAIL prio_mode_wins: mode=%0d paused=%b frame=%0d want 1/0/0", o_mode, o_paused, o_frame); end
    boundary();
    total++; if (o_paused !== 1'b1 || o_frame !== 10'd0) begin bad++; $display("FAIL prio_pause_after: paused=%b frame=%0d want 1/0", o_paused, o_frame); end
    boundary();
    total++; if (o_frame !== 10'd0) begin bad++; $display("FAIL prio_step_cleared: frame=%0d want 0", o_frame); end
    i_pause_req = 1'b0;
    boundary();
    total++; if (o_paused !== 1'b0 || o_frame !== 10'd0) begin bad++; $display("FAIL prio_resume: paused=%b frame=%0d want 0/0", o_paused, o_frame); end
    boundary();
    total++; if (o_frame !== 10'd1 || o_intro_done !== 1'b0) begin bad++; $display("FAIL prio_back_to_intro: frame=%0d done=%b want 1/0", o_frame, o_intro_done); end
  endtask

  task automatic test_reset_mid();
    int t0;
    repeat (699) boundary();
    total++; if (o_frame !== 10'd700) begin bad++; $display("FAIL rstmid_pre_frame: got %0d want 700", o_frame); end
    i_mode_req = 2'd0;
    i_pid_req  = 2'd0;
    i_vsync    = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    total++; if (o_frame !== 10'd0 || o_intro_done !== 1'b0 || o_frame_tick !== 1'b0) begin bad++; $display("FAIL rstmid_state: frame=%0d done=%b tick=%b want 0/0/0", o_frame, o_intro_done, o_frame_tick); end
    total++; if (o_pid !== 2'd0 || o_mode !== 2'd1 - 2'd1 || o_paused !== 1'b0) begin bad++; $display("FAIL rstmid_regs: pid=%0d mode=%0d paused=%b want 0/0/0", o_pid, o_mode, o_paused); end
    t0 = ticks;
    cyc(5);
    total++; if (o_frame !== 10'd0 || ticks - t0 !== 0) begin bad++; $display("FAIL rstmid_no_boundary: frame=%0d ticks=%0d want 0/0", o_frame, ticks - t0); end
    i_vsync = 1'b0;
    cyc(2);
    boundary();
    total++; if (o_frame !== 10'd1 || o_intro_done !== 1'b0 || o_mode !== 2'd0) begin bad++; $display("FAIL rstmid_resume: frame=%0d done=%b mode=%0d want 1/0/0", o_frame, o_intro_done, o_mode); end
  endtask

  initial begin
    test_reset();
    test_intro_wrap();
    test_speed();
    test_pause_step();
    test_mode_restart();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
